// File: rtl/adder_pipe_acc.sv
// Two-stage pipelined adder/accumulator with valid/ready handshakes on both sides.
// Define ADDER_PIPE_ACC_SAT_EN for a saturating accumulator instead of modulo wrap.
module adder_pipe_acc #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic                 mode_i,
   input  logic                 clear_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [ACC_WIDTH-1:0] sum_o,
   output logic                 is_odd_o,
   output logic                 ovf_o,
   output logic [CNT_WIDTH-1:0] count_o
);

   localparam int unsigned PAIR_W = WIDTH + 1;
   localparam int unsigned T_W    = ACC_WIDTH + 1;

   logic                 s1_valid_q, s1_valid_d;
   logic [PAIR_W-1:0]    s1_pair_q, s1_pair_d;
   logic                 s1_mode_q, s1_mode_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] cnt_out_q, cnt_out_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef ADDER_PIPE_ACC_SAT_EN
   logic                 sat_q, sat_d, sat_base;
`endif

   logic                 s1_load_c, s2_load_c;
   logic [ACC_WIDTH-1:0] acc_base, acc_new;
   logic [CNT_WIDTH-1:0] cnt_base, cnt_new;
   logic [T_W-1:0]       t_sum;
   logic                 ovf_new;

   assign s2_load_c = s1_valid_q && (!s2_valid_q || ready_i);
   assign s1_load_c = !s1_valid_q || s2_load_c;

   assign ready_o  = s1_load_c;
   assign valid_o  = s2_valid_q;
   assign sum_o    = sum_q;
   assign is_odd_o = sum_q[0];
   assign ovf_o    = ovf_q;
   assign count_o  = cnt_out_q;

   // Next-state: clear is applied before any accumulate loading on the same edge.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_pair_d  = s1_pair_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      sum_d      = sum_q;
      ovf_d      = ovf_q;
      cnt_out_d  = cnt_out_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      acc_base   = clear_i ? '0 : acc_q;
      cnt_base   = clear_i ? '0 : cnt_q;
      t_sum      = T_W'(acc_base) + T_W'(s1_pair_q);
      cnt_new    = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
`ifdef ADDER_PIPE_ACC_SAT_EN
      sat_d      = sat_q;
      sat_base   = clear_i ? 1'b0 : sat_q;
      if (sat_base) begin
         acc_new = '1;
         ovf_new = 1'b0;
      end else if (t_sum[ACC_WIDTH]) begin
         acc_new = '1;
         ovf_new = 1'b1;
      end else begin
         acc_new = t_sum[ACC_WIDTH-1:0];
         ovf_new = 1'b0;
      end
`else
      acc_new    = t_sum[ACC_WIDTH-1:0];
      ovf_new    = t_sum[ACC_WIDTH];
`endif

      if (clear_i) begin
         acc_d = '0;
         cnt_d = '0;
`ifdef ADDER_PIPE_ACC_SAT_EN
         sat_d = 1'b0;
`endif
      end

      if (s1_load_c) begin
         s1_valid_d = valid_i;
         if (valid_i) begin
            s1_pair_d = PAIR_W'(a_i) + PAIR_W'(b_i);
            s1_mode_d = mode_i;
         end
      end

      if (s2_load_c) begin
         s2_valid_d = 1'b1;
         if (s1_mode_q) begin
            acc_d     = acc_new;
            cnt_d     = cnt_new;
            sum_d     = acc_new;
            ovf_d     = ovf_new;
            cnt_out_d = cnt_new;
`ifdef ADDER_PIPE_ACC_SAT_EN
            sat_d     = sat_base | ovf_new;
`endif
         end else begin
            sum_d     = ACC_WIDTH'(s1_pair_q);
            ovf_d     = 1'b0;
            cnt_out_d = cnt_base;
         end
      end else if (s2_valid_q && ready_i) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         s1_valid_q <= 1'b0;
         s1_pair_q  <= '0;
         s1_mode_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         ovf_q      <= 1'b0;
         cnt_out_q  <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
`ifdef ADDER_PIPE_ACC_SAT_EN
         sat_q      <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_pair_q  <= s1_pair_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         sum_q      <= sum_d;
         ovf_q      <= ovf_d;
         cnt_out_q  <= cnt_out_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
`ifdef ADDER_PIPE_ACC_SAT_EN
         sat_q      <= sat_d;
`endif
      end
   end

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Self-checking bench for adder_pipe_acc: directed tables plus randomized traffic
// against an arithmetic reference model; a second instance uses ACC_WIDTH=9.
module tb_adder_pipe_acc;

   logic       clk = 1'b0;
   logic       reset_i, valid_i, mode_i, clear_i, ready_i;
   logic [7:0] a_i, b_i;
   logic       ready0, valid0, odd0, ovf0;
   logic       ready1, valid1, odd1, ovf1;
   logic [15:0] sum0;
   logic [8:0]  sum1;
   logic [7:0]  cnt0, cnt1;

   always #5 clk = ~clk;

   adder_pipe_acc u_dut (
      .clk(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready0),
      .a_i(a_i), .b_i(b_i), .mode_i(mode_i), .clear_i(clear_i),
      .valid_o(valid0), .ready_i(ready_i), .sum_o(sum0), .is_odd_o(odd0),
      .ovf_o(ovf0), .count_o(cnt0)
   );

   adder_pipe_acc #(.WIDTH(8), .ACC_WIDTH(9), .CNT_WIDTH(8)) u_small (
      .clk(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready1),
      .a_i(a_i), .b_i(b_i), .mode_i(mode_i), .clear_i(clear_i),
      .valid_o(valid1), .ready_i(ready_i), .sum_o(sum1), .is_odd_o(odd1),
      .ovf_o(ovf1), .count_o(cnt1)
   );

   typedef struct { longint pair; bit mode; int cyc; } item_t;
   typedef struct { longint s0; longint s1; int c0; int c1; bit o0; bit o1; bit odd0; int lat; } got_t;
   typedef struct { logic [7:0] a; logic [7:0] b; bit mode; bit clr;
                    int exp_sum; bit exp_odd; bit exp_ovf; int exp_cnt; } vec_t;

   item_t  sb[$];
   got_t   got[$];
   bit     clr_at[int];
   longint acc_m[2];
   int     cnt_m[2];
   bit     sat_m[2];
   int     n_in = 0, n_pop = 0, cyc = 0;
   int     n_chk = 0, n_fail = 0;
   bit     hold_v = 1'b0;
   longint hold_s0, hold_s1;
   int     hold_c0;
   bit     hold_o0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint got_v, input longint exp_v);
      n_chk++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got_v, exp_v, cyc);
      end
   endtask

   // Scoreboard and reference model, sampled mid-cycle ahead of the next active edge.
   always @(negedge clk) begin
      if (reset_i) begin
         sb.delete();
         clr_at.delete();
         n_in = 0;
         n_pop = 0;
         hold_v = 1'b0;
         for (int d = 0; d < 2; d++) begin
            acc_m[d] = 0; cnt_m[d] = 0; sat_m[d] = 0;
         end
      end else begin
         if (hold_v) begin
            chk("stall_valid", valid0, 1);
            chk("stall_sum", sum0, hold_s0);
            chk("stall_sum_small", sum1, hold_s1);
            chk("stall_count", cnt0, hold_c0);
            chk("stall_ovf", ovf0, hold_o0);
         end
         hold_v  = valid0 && !ready_i;
         hold_s0 = sum0; hold_s1 = sum1; hold_c0 = cnt0; hold_o0 = ovf0;
         if (clear_i) clr_at[n_pop + (valid0 ? 1 : 0)] = 1'b1;
         if (valid0 && ready_i) begin
            if (sb.size() == 0) begin
               chk("spurious_output", 1, 0);
            end else begin
               item_t  it;
               longint es[2];
               bit     eo[2];
               int     ec[2];
               got_t   gr;
               it = sb.pop_front();
               if (clr_at.exists(n_pop)) begin
                  for (int d = 0; d < 2; d++) begin
                     acc_m[d] = 0; cnt_m[d] = 0; sat_m[d] = 0;
                  end
               end
               for (int d = 0; d < 2; d++) begin
                  longint lim, t;
                  lim = (d == 0) ? 65536 : 512;
                  if (!it.mode) begin
                     es[d] = it.pair; eo[d] = 0; ec[d] = cnt_m[d];
                  end else begin
                     t = acc_m[d] + it.pair;
                     if (cnt_m[d] < 255) cnt_m[d]++;
                     ec[d] = cnt_m[d];
`ifdef ADDER_PIPE_ACC_SAT_EN
                     if (sat_m[d]) begin
                        acc_m[d] = lim - 1; eo[d] = 0;
                     end else if (t >= lim) begin
                        acc_m[d] = lim - 1; eo[d] = 1; sat_m[d] = 1;
                     end else begin
                        acc_m[d] = t; eo[d] = 0;
                     end
`else
                     eo[d] = (t >= lim);
                     acc_m[d] = t % lim;
`endif
                     es[d] = acc_m[d];
                  end
               end
               chk("model_sum", sum0, es[0]);
               chk("model_odd", odd0, es[0] % 2);
               chk("model_ovf", ovf0, eo[0]);
               chk("model_count", cnt0, ec[0]);
               chk("model_sum_small", sum1, es[1]);
               chk("model_odd_small", odd1, es[1] % 2);
               chk("model_ovf_small", ovf1, eo[1]);
               chk("model_count_small", cnt1, ec[1]);
               gr.s0 = sum0; gr.s1 = sum1; gr.c0 = cnt0; gr.c1 = cnt1;
               gr.o0 = ovf0; gr.o1 = ovf1; gr.odd0 = odd0; gr.lat = cyc - it.cyc;
               got.push_back(gr);
            end
            n_pop++;
         end
         if (valid_i && ready0) begin
            item_t ni;
            ni.pair = longint'(a_i) + longint'(b_i);
            ni.mode = mode_i;
            ni.cyc  = cyc;
            sb.push_back(ni);
            n_in++;
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input bit m, input bit c);
      int w;
      w = 0;
      valid_i = 1'b1; a_i = a; b_i = b; mode_i = m; clear_i = c;
      @(negedge clk);
      while (!ready0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("send_accepted", ready0, 1);
      @(posedge clk); #1;
      valid_i = 1'b0; clear_i = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && n_pop != n_in; i++) begin
         @(posedge clk); #1;
      end
      chk("drain_complete", n_pop, n_in);
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
   endtask

   vec_t       tbl[8];
   logic [7:0] bp_a[4], bp_b[4];
   longint     exp4_s1[4];
   bit         exp4_o1[4];
   int         g, k;
   longint     held;

   initial begin
      tbl[0] = '{8'd0,   8'd1,   0, 0, 1,    1, 0, 0};
      tbl[1] = '{8'd2,   8'd2,   0, 0, 4,    0, 0, 0};
      tbl[2] = '{8'd9,   8'd10,  0, 0, 19,   1, 0, 0};
      tbl[3] = '{8'd15,  8'd5,   0, 0, 20,   0, 0, 0};
      tbl[4] = '{8'd4,   8'd7,   0, 0, 11,   1, 0, 0};
      tbl[5] = '{8'd255, 8'd255, 1, 1, 510,  0, 0, 1};
      tbl[6] = '{8'd255, 8'd255, 1, 0, 1020, 0, 0, 2};
      tbl[7] = '{8'd255, 8'd255, 1, 0, 1530, 0, 0, 3};
      bp_a = '{8'd1, 8'd3, 8'd5, 8'd7};
      bp_b = '{8'd2, 8'd4, 8'd6, 8'd8};
`ifdef ADDER_PIPE_ACC_SAT_EN
      exp4_s1 = '{510, 511, 511, 511};
`else
      exp4_s1 = '{510, 511, 0, 1};
`endif
      exp4_o1 = '{0, 0, 1, 0};

      reset_i = 1'b1; valid_i = 1'b0; mode_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
      a_i = '0; b_i = '0;
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_valid", valid0, 0);
      chk("rst_sum", sum0, 0);
      chk("rst_odd", odd0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_ready", ready0, 1);
      @(posedge clk); #1;

      // Pair-add then accumulate vectors, streamed back to back.
      g = got.size();
      for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].clr);
      drain();
      chk("tbl_results", got.size() - g, 8);
      for (int i = 0; i < 8; i++) begin
         if (g + i < got.size()) begin
            chk($sformatf("tbl%0d_sum", i), got[g+i].s0, tbl[i].exp_sum);
            chk($sformatf("tbl%0d_odd", i), got[g+i].odd0, tbl[i].exp_odd);
            chk($sformatf("tbl%0d_ovf", i), got[g+i].o0, tbl[i].exp_ovf);
            chk($sformatf("tbl%0d_count", i), got[g+i].c0, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_latency", i), got[g+i].lat, 2);
         end
      end

      // Backpressure: consumer stalls while the producer streams four pairs.
      g = got.size(); k = 0; held = 0;
      for (int c = 0; c < 40; c++) begin
         ready_i = (c >= 5);
         valid_i = (k < 4);
         mode_i  = 1'b0;
         if (k < 4) begin a_i = bp_a[k]; b_i = bp_b[k]; end
         @(negedge clk);
         if (c == 2) begin
            chk("bp_ready_low", ready0, 0);
            chk("bp_accepted_before_stall", k, 2);
            held = sum0;
         end
         if (c == 4) chk("bp_sum_held", sum0, held);
         if (valid_i && ready0) k++;
         @(posedge clk); #1;
         if (k == 4 && n_pop == n_in) break;
      end
      valid_i = 1'b0; ready_i = 1'b1;
      chk("bp_sent", k, 4);
      chk("bp_results", got.size() - g, 4);
      for (int i = 0; i < 4; i++) begin
         if (g + i < got.size()) begin
            chk($sformatf("bp%0d_sum", i), got[g+i].s0, longint'(bp_a[i]) + longint'(bp_b[i]));
            chk($sformatf("bp%0d_count", i), got[g+i].c0, 3);
         end
      end

      // Accumulator overflow on the 9-bit instance.
      pulse_clear();
      g = got.size();
      send(8'd255, 8'd255, 1, 0);
      send(8'd1, 8'd0, 1, 0);
      send(8'd1, 8'd0, 1, 0);
      send(8'd1, 8'd0, 1, 0);
      drain();
      chk("ovf_results", got.size() - g, 4);
      for (int i = 0; i < 4; i++) begin
         if (g + i < got.size()) begin
            chk($sformatf("ovf%0d_sum_small", i), got[g+i].s1, exp4_s1[i]);
            chk($sformatf("ovf%0d_flag_small", i), got[g+i].o1, exp4_o1[i]);
            chk($sformatf("ovf%0d_sum_wide", i), got[g+i].s0, 510 + i);
         end
      end

      // Clear on the same edge as an accumulate load into the output stage.
      pulse_clear();
      send(8'd50, 8'd50, 1, 0);
      drain();
      chk("pre_clear_acc", got[got.size()-1].s0, 100);
      g = got.size();
      send(8'd3, 8'd4, 1, 0);
      pulse_clear();
      send(8'd1, 8'd2, 1, 0);
      drain();
      chk("clr_results", got.size() - g, 2);
      if (got.size() >= g + 2) begin
         chk("clr_first_sum", got[g].s0, 7);
         chk("clr_first_count", got[g].c0, 1);
         chk("clr_first_ovf", got[g].o0, 0);
         chk("clr_first_sum_small", got[g].s1, 7);
         chk("clr_next_sum", got[g+1].s0, 10);
         chk("clr_next_count", got[g+1].c0, 2);
      end

      // Reset with both stages full and the consumer stalled.
      ready_i = 1'b0;
      send(8'd10, 8'd20, 0, 0);
      send(8'd30, 8'd40, 0, 0);
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst2_valid", valid0, 0);
      chk("rst2_sum", sum0, 0);
      chk("rst2_odd", odd0, 0);
      chk("rst2_ovf", ovf0, 0);
      chk("rst2_count", cnt0, 0);
      chk("rst2_ready", ready0, 1);
      chk("rst2_valid_small", valid1, 0);
      @(posedge clk); #1;
      ready_i = 1'b1;
      g = got.size();
      send(8'd6, 8'd7, 1, 0);
      drain();
      chk("rst2_results", got.size() - g, 1);
      if (got.size() > g) begin
         chk("rst2_first_sum", got[g].s0, 13);
         chk("rst2_first_count", got[g].c0, 1);
      end

      // Sample counter saturates at all-ones.
      pulse_clear();
      g = got.size();
      for (int i = 0; i < 260; i++) send(8'd0, 8'd0, 1, 0);
      drain();
      if (got.size() >= g + 260) begin
         chk("cnt_254", got[g+253].c0, 254);
         chk("cnt_255", got[g+254].c0, 255);
         chk("cnt_sat", got[g+259].c0, 255);
         chk("cnt_sat_small", got[g+259].c1, 255);
      end else begin
         chk("cnt_results", got.size() - g, 260);
      end

      // Randomized traffic, stalls, clears and occasional resets.
      for (int c = 0; c < 800; c++) begin
         valid_i = ($urandom_range(0, 3) != 0);
         a_i     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         b_i     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         mode_i  = ($urandom_range(0, 2) != 0);
         clear_i = ($urandom_range(0, 19) == 0);
         ready_i = ($urandom_range(0, 9) < 7);
         reset_i = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      valid_i = 1'b0; clear_i = 1'b0; reset_i = 1'b0; ready_i = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
      $fatal(1);
   end

endmodule
